// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   ADDR_W / INSTR_W : word-address and instruction widths
//   fetch_state_e    : instruction-fetch FSM state encodings
package mips_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: DEPTH x WIDTH circular FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write an entry (caller guarantees space)
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the buffer; overrides push and pop
//   rdata      : head entry
//   count      : current occupancy (0..DEPTH)
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);
  assign rdata  = mem[rptr];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one word request at a time to instruction
// memory and buffers responses for decode.
//   clk, rst_n              : clock, asynchronous active-low reset
//   pc                      : word address from the program counter
//   fetch_en                : permit new fetches
//   flush                   : redirect; drops buffered and in-flight fetches
//   pc_stall                : 0 only in the cycle a response is accepted
//   imem_req/addr/gnt       : request handshake to instruction memory
//   imem_rvalid/rdata       : response from instruction memory
//   instr/instr_pc/valid/ready : stream to decode
module inst_fetch
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               fetch_en,
  input  logic               flush,
  output logic               pc_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      discard_q, discard_d;
  logic                      push, pop;
  logic [CW-1:0]             count;
  logic [OW-1:0]             occ_next;
  logic [ADDR_W+INSTR_W-1:0] head;

  assign push        = (state_q == WAIT) && imem_rvalid && !discard_q && !flush;
  assign pop         = instr_valid && instr_ready && !flush;
  assign instr_valid = (count != '0);
  assign occ_next    = {1'b0, count} + OW'(push) - OW'(pop);
  assign pc_stall    = !push;
  assign imem_addr   = addr_q;
  assign instr       = head[INSTR_W-1:0];
  assign instr_pc    = head[ADDR_W+INSTR_W-1:INSTR_W];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({addr_q, imem_rdata}),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    imem_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en && !flush && ({1'b0, count} < DEPTH_C)) begin
          state_d = ISSUE;
          addr_d  = pc;
        end
      end
      ISSUE: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_d = WAIT;
          if (flush) discard_d = 1'b1;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (fetch_en && !flush && (occ_next < DEPTH_C)) begin
            state_d = ISSUE;
            // The PC register advances at this same edge when the response is
            // accepted, so latch the value it will hold next cycle.
            addr_d  = push ? (pc + ADDR_W'(1)) : pc;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
